waveform_streamer: RTL and testbench

WAVEFORM_STREAMER -- requirements
Module: waveform_streamer

---
 rtl/waveform_streamer_pkg.sv | 22 ++
 rtl/waveform_streamer_phase_accumulator.sv | 48 ++++
 rtl/waveform_streamer.sv | 107 ++++++++++
 tb/tb_waveform_streamer.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/waveform_streamer_pkg.sv
// waveform_streamer_pkg: shared constants, FSM state encoding and sample-array type
// for the waveform generator / streamer pair.
`default_nettype none

package waveform_streamer_pkg;

  localparam int N_SAMPLES = 256;
  localparam int DATA_W    = 8;
  localparam int PHASE_W   = 16;
  localparam int IDX_W     = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DONE   = 2'd2
  } state_t;

  typedef logic [N_SAMPLES-1:0][DATA_W-1:0] sample_array_t;

endpackage

`default_nettype wire

// File: rtl/waveform_streamer_phase_accumulator.sv
// phase_accumulator: latched frequency step, phase register and raw add carry.
`default_nettype none

module phase_accumulator #(
  parameter int PHASE_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load_i,
  input  logic [PHASE_W-1:0] step_i,
  input  logic               adv_i,
  output logic [7:0]         idx_o,
  output logic               carry_o
);

  logic [PHASE_W-1:0] phase_q, phase_d;
  logic [PHASE_W-1:0] step_q, step_d;
  logic [PHASE_W:0]   sum;

  assign sum     = {1'b0, phase_q} + {1'b0, step_q};
  assign carry_o = sum[PHASE_W];
  assign idx_o   = phase_q[PHASE_W-1 -: 8];

  // Load wins over advance: a new run always restarts at phase 0.
  always_comb begin
    phase_d = phase_q;
    step_d  = step_q;
    if (load_i) begin
      phase_d = '0;
      step_d  = step_i;
    end else if (adv_i) begin
      phase_d = sum[PHASE_W-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q <= '0;
      step_q  <= '0;
    end else begin
      phase_q <= phase_d;
      step_q  <= step_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/waveform_streamer.sv
// waveform_streamer: captures a 256-entry waveform on start and plays it out through
// a valid/ready port using a phase accumulator, for a finite or continuous number of periods.
`default_nettype none

module waveform_streamer #(
  parameter int N_SAMPLES = 256,
  parameter int DATA_W    = 8,
  parameter int PHASE_W   = 16
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  input  logic                              stop,
  input  logic [PHASE_W-1:0]                phase_step,
  input  logic [7:0]                        n_periods,
  input  logic [N_SAMPLES-1:0][DATA_W-1:0]  wave_in,
  output logic [DATA_W-1:0]                 sample_out,
  output logic                              sample_valid,
  input  logic                              sample_ready,
  output logic                              busy,
  output logic                              period_done,
  output logic                              done
);

  import waveform_streamer_pkg::*;

  state_t                           state_q, state_d;
  logic [N_SAMPLES-1:0][DATA_W-1:0] buf_q;
  logic [7:0]                       nper_q;
  logic [7:0]                       pcnt_q, pcnt_d;
  logic                             pd_q;

  logic       accept;
  logic       hs;
  logic       wrap;
  logic       carry;
  logic [7:0] idx;
  logic [7:0] pcnt_inc;

  assign accept   = (state_q == IDLE) && start && !stop && (phase_step != '0);
  // stop suppresses the handshake so an aborting cycle never advances or wraps.
  assign hs       = (state_q == STREAM) && sample_ready && !stop;
  assign wrap     = hs && carry;
  assign pcnt_inc = pcnt_q + 8'd1;

  phase_accumulator #(
    .PHASE_W (PHASE_W)
  ) u_phase (
    .clk     (clk),
    .rst     (rst),
    .load_i  (accept),
    .step_i  (phase_step),
    .adv_i   (hs),
    .idx_o   (idx),
    .carry_o (carry)
  );

  always_comb begin
    state_d = state_q;
    pcnt_d  = pcnt_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = STREAM;
          pcnt_d  = '0;
        end
      end
      STREAM: begin
        if (stop) begin
          state_d = IDLE;
        end else if (wrap) begin
          pcnt_d = pcnt_inc;
          if ((nper_q != 8'd0) && (pcnt_inc == nper_q)) state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      pcnt_q  <= '0;
      nper_q  <= '0;
      pd_q    <= 1'b0;
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
      pcnt_q  <= pcnt_d;
      pd_q    <= wrap;
      if (accept) begin
        nper_q <= n_periods;
        buf_q  <= wave_in;
      end
    end
  end

  assign sample_valid = (state_q == STREAM);
  assign sample_out   = sample_valid ? buf_q[idx] : '0;
  assign busy         = (state_q != IDLE);
  assign done         = (state_q == DONE);
  assign period_done  = pd_q;

endmodule

`default_nettype wire

// File: tb/tb_waveform_streamer.sv
// tb_waveform_streamer: scoreboard bench for waveform_streamer.
`default_nettype none

module tb_waveform_streamer;

  import waveform_streamer_pkg::*;

  logic          clk = 1'b0;
  logic          rst, start, stop, sample_ready;
  logic [15:0]   phase_step;
  logic [7:0]    n_periods;
  sample_array_t wave_in;
  logic [7:0]    sample_out;
  logic          sample_valid, busy, period_done, done;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct packed {
    logic [7:0] s;
    logic       w;
    logic       last;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] wave_m [256];

  always #5 clk = ~clk;

  waveform_streamer dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .stop         (stop),
    .phase_step   (phase_step),
    .n_periods    (n_periods),
    .wave_in      (wave_in),
    .sample_out   (sample_out),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .busy         (busy),
    .period_done  (period_done),
    .done         (done)
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_wave(input int kind);
    logic [7:0] v;
    for (int i = 0; i < 256; i++) begin
      case (kind)
        0:       v = 8'(i);
        1:       v = 8'(i * 3 + 7);
        2:       v = 8'(255 - i);
        default: v = 8'(i) ^ 8'hA5;
      endcase
      wave_in[i] = v;
      wave_m[i]  = v;
    end
  endtask

  task automatic scramble_wave();
    for (int i = 0; i < 256; i++) wave_in[i] = ~wave_in[i];
  endtask

  // Reference phase model: one entry per expected handshake.
  task automatic push_expected(input logic [15:0] step, input logic [7:0] nper, input int max_n);
    logic [15:0] ph;
    logic [16:0] sum;
    logic [7:0]  cnt;
    exp_t        e;
    exp_q.delete();
    ph  = '0;
    cnt = '0;
    for (int n = 0; n < max_n; n++) begin
      sum    = {1'b0, ph} + {1'b0, step};
      e.s    = wave_m[ph[15:8]];
      e.w    = sum[16];
      e.last = 1'b0;
      ph     = sum[15:0];
      if (e.w) cnt = cnt + 8'd1;
      if (e.w && nper != 8'd0 && cnt == nper) e.last = 1'b1;
      exp_q.push_back(e);
      if (e.last) break;
    end
  endtask

  task automatic do_start(input logic [15:0] step, input logic [7:0] nper);
    phase_step = step;
    n_periods  = nper;
    start      = 1'b1;
    tick();
    start      = 1'b0;
  endtask

  task automatic monitor(input int max_cycles, input int stall_at, input bit expect_finish);
    bit   exp_pd   = 1'b0;
    bit   exp_done = 1'b0;
    bit   finished = 1'b0;
    bit   stalled;
    exp_t e;
    for (int c = 0; c < max_cycles && !finished; c++) begin
      stalled      = (stall_at >= 0) && (c >= stall_at) && (c < stall_at + 5);
      sample_ready = !stalled;
      check_eq("period_done", period_done, exp_pd);
      check_eq("done", done, exp_done);
      exp_pd = 1'b0;
      if (exp_done) begin
        check_eq("valid_after_done", sample_valid, 1'b0);
        finished = 1'b1;
      end else begin
        check_eq("valid", sample_valid, 1'b1);
        if (exp_q.size() == 0) begin
          check_eq("extra_sample_valid", sample_valid, 1'b0);
        end else if (stalled) begin
          check_eq("stall_hold", sample_out, exp_q[0].s);
        end else begin
          e = exp_q.pop_front();
          check_eq("sample", sample_out, e.s);
          exp_pd   = e.w;
          exp_done = e.last;
        end
      end
      tick();
      start = 1'b0;
    end
    sample_ready = 1'b1;
    if (expect_finish) check_eq("run_finished", finished, 1'b1);
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_valid"}, sample_valid, 1'b0);
    check_eq({tag, "_busy"}, busy, 1'b0);
    check_eq({tag, "_sample"}, sample_out, 8'h00);
    check_eq({tag, "_pd"}, period_done, 1'b0);
    check_eq({tag, "_done"}, done, 1'b0);
  endtask

  initial begin
    rst          = 1'b1;
    start        = 1'b0;
    stop         = 1'b0;
    sample_ready = 1'b1;
    phase_step   = '0;
    n_periods    = '0;
    load_wave(0);
    repeat (3) tick();
    check_all_zero("reset");
    rst = 1'b0;
    tick();

    // (a) one period, unit step through every entry
    load_wave(0);
    push_expected(16'h0100, 8'd1, 1000);
    do_start(16'h0100, 8'd1);
    monitor(400, -1, 1'b1);
    check_eq("a_idle_busy", busy, 1'b0);
    check_eq("a_idle_valid", sample_valid, 1'b0);

    // (b) fractional step, two periods; inputs change and start re-pulses after capture
    load_wave(0);
    push_expected(16'h0280, 8'd2, 1000);
    do_start(16'h0280, 8'd2);
    scramble_wave();
    phase_step = 16'h1111;
    n_periods  = 8'd1;
    start      = 1'b1;
    monitor(400, -1, 1'b1);

    // (c) five-cycle back-pressure mid-stream
    load_wave(1);
    push_expected(16'h0300, 8'd1, 1000);
    do_start(16'h0300, 8'd1);
    monitor(400, 40, 1'b1);

    // (d) stop coinciding with a wrapping handshake
    load_wave(3);
    push_expected(16'h0100, 8'd2, 1000);
    do_start(16'h0100, 8'd2);
    monitor(255, -1, 1'b0);
    check_eq("d_last_sample", sample_out, wave_m[255]);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check_eq("d_valid", sample_valid, 1'b0);
    check_eq("d_busy", busy, 1'b0);
    check_eq("d_pd", period_done, 1'b0);
    check_eq("d_done", done, 1'b0);
    tick();
    check_eq("d_pd2", period_done, 1'b0);
    check_eq("d_done2", done, 1'b0);

    // (e) ignored starts
    phase_step = 16'h0000;
    n_periods  = 8'd1;
    start      = 1'b1;
    tick();
    start = 1'b0;
    check_eq("e_zero_step_busy", busy, 1'b0);
    check_eq("e_zero_step_valid", sample_valid, 1'b0);
    phase_step = 16'h0100;
    start      = 1'b1;
    stop       = 1'b1;
    tick();
    start = 1'b0;
    stop  = 1'b0;
    check_eq("e_start_stop_busy", busy, 1'b0);
    tick();
    check_eq("e_start_stop_busy2", busy, 1'b0);

    // (g) continuous run past 256 periods: counter wraps silently
    load_wave(0);
    push_expected(16'h8000, 8'd0, 520);
    do_start(16'h8000, 8'd0);
    monitor(516, -1, 1'b0);
    check_eq("g_still_busy", busy, 1'b1);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check_eq("g_stopped_busy", busy, 1'b0);

    // (f) asynchronous reset mid-stream, then a fresh run
    load_wave(2);
    push_expected(16'h0123, 8'd0, 100);
    do_start(16'h0123, 8'd0);
    monitor(50, -1, 1'b0);
    #2 rst = 1'b1;
    #1 check_all_zero("f_async_rst");
    tick();
    rst = 1'b0;
    tick();
    load_wave(3);
    push_expected(16'h4000, 8'd1, 100);
    do_start(16'h4000, 8'd1);
    monitor(20, -1, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
